// File: rtl/nice_mem_burst_if_if.sv
// NICE ICB master channel: command and response halves of the core memory port.
interface nice_mem_burst_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              nice_icb_cmd_valid;
  logic              nice_icb_cmd_ready;
  logic [ADDR_W-1:0] nice_icb_cmd_addr;
  logic              nice_icb_cmd_read;
  logic [DATA_W-1:0] nice_icb_cmd_wdata;
  logic [1:0]        nice_icb_cmd_size;
  logic              nice_icb_rsp_valid;
  logic              nice_icb_rsp_ready;
  logic [DATA_W-1:0] nice_icb_rsp_rdata;
  logic              nice_icb_rsp_err;

  modport master (
    output nice_icb_cmd_valid, nice_icb_cmd_addr, nice_icb_cmd_read,
           nice_icb_cmd_wdata, nice_icb_cmd_size, nice_icb_rsp_ready,
    input  nice_icb_cmd_ready, nice_icb_rsp_valid, nice_icb_rsp_rdata, nice_icb_rsp_err
  );

  modport slave (
    input  nice_icb_cmd_valid, nice_icb_cmd_addr, nice_icb_cmd_read,
           nice_icb_cmd_wdata, nice_icb_cmd_size, nice_icb_rsp_ready,
    output nice_icb_cmd_ready, nice_icb_rsp_valid, nice_icb_rsp_rdata, nice_icb_rsp_err
  );
endinterface

// File: rtl/nice_mem_burst_if.sv
// Burst load/store engine on the NICE ICB port with in-order read FIFO.
// Optional NICE_MEMIF_STRIDE_EN: per-request byte stride instead of fixed 4.
module nice_mem_burst_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic               nice_clk,
  input  logic               nice_rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [ADDR_W-1:0]  req_base_addr,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [ADDR_W-1:0]  req_stride,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  nice_mem_burst_if_if.master icb,
  output logic               nice_mem_holdup
);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q, stride_q;
  logic [LEN_W-1:0]  len_q, idx_q;
  logic [CW-1:0]     outst_q, fifo_cnt;
  logic [PW-1:0]     wptr, rptr;
  logic [DATA_W-1:0] mem [MAX_OUTST];

  logic issue, is_store, load_room, store_room;
  logic cmd_fire, rsp_fire, push, pop;

  assign issue      = (state == S_ISSUE);
  assign is_store   = (op_q == 2'b11);
  // Load issue reserves a FIFO slot per command so responses never stall.
  assign load_room  = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < {1'b0, MAX_C};
  assign store_room = outst_q < MAX_C;

  assign icb.nice_icb_cmd_valid = issue & (is_store ? (wr_valid & store_room) : load_room);
  assign icb.nice_icb_cmd_addr  = addr_q;
  assign icb.nice_icb_cmd_read  = issue & ~is_store;
  assign icb.nice_icb_cmd_wdata = (issue & is_store) ? wr_data : '0;
  assign icb.nice_icb_cmd_size  = 2'b10;
  assign icb.nice_icb_rsp_ready = busy;

  assign wr_ready = issue & is_store & wr_valid & store_room & icb.nice_icb_cmd_ready;

  assign cmd_fire = icb.nice_icb_cmd_valid & icb.nice_icb_cmd_ready;
  // Responses with nothing outstanding (e.g. stragglers after reset) are dropped.
  assign rsp_fire = icb.nice_icb_rsp_valid & icb.nice_icb_rsp_ready & (outst_q != '0);
  assign push     = rsp_fire & ~is_store;
  assign pop      = rd_valid & rd_ready;

  assign rd_valid        = (fifo_cnt != '0);
  assign rd_data         = rd_valid ? mem[rptr] : '0;
  assign nice_mem_holdup = busy;

`ifndef NICE_MEMIF_STRIDE_EN
  logic unused_stride;
  assign unused_stride = ^req_stride;
`endif

  always_ff @(posedge nice_clk) begin
    if (push) mem[wptr] <= icb.nice_icb_rsp_rdata;
  end

  always_ff @(posedge nice_clk) begin
    if (nice_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge nice_clk) begin
    if (nice_rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      outst_q   <= '0;
    end else begin
      done    <= 1'b0;
      outst_q <= outst_q + CW'(cmd_fire) - CW'(rsp_fire);
      if (rsp_fire && icb.nice_icb_rsp_err) err <= 1'b1;
      case (state)
        S_IDLE: if (req_valid) begin
          op_q      <= req_op;
          addr_q    <= req_base_addr;
          len_q     <= req_len;
`ifdef NICE_MEMIF_STRIDE_EN
          stride_q  <= req_stride;
`else
          stride_q  <= ADDR_W'(4);
`endif
          idx_q     <= '0;
          outst_q   <= '0;
          err       <= 1'b0;
          req_ready <= 1'b0;
          if (req_op == 2'b00 || req_len == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_ISSUE;
            busy  <= 1'b1;
          end
        end
        S_ISSUE: if (cmd_fire) begin
          idx_q  <= idx_q + LEN_W'(1);
          addr_q <= addr_q + stride_q;
          if (idx_q + LEN_W'(1) == len_q) state <= S_DRAIN;
        end
        S_DRAIN: if (outst_q == '0 && fifo_cnt == '0) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/nice_mem_burst_if.md
Name: nice_mem_burst_if

Overview:
- Parametrised successor of the NICE memory interface.
- Executes one burst per request: N-word load of LHS/RHS operands, or N-word store of results, over the NICE ICB master port.
- Supports multiple outstanding transactions, an in-order read-data FIFO and valid/ready streams toward the accelerator datapath.
- Sits between the NN accelerator controller/datapath and the core's NICE memory channel.

Parameters:
- ADDR_W, 32, address width; ICB address and base/stride width.
- DATA_W, 32, word width; ICB data width.
- LEN_W, 16, burst length counter width (words).
- MAX_OUTST, 4, maximum in-flight ICB commands; also read FIFO depth (power of two, ≥2).

Ports:
- nice_clk  in  1  clock.
- nice_rst  in  1  synchronous active-high reset.
- req_valid  in  1  burst request.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  01 load LHS, 10 load RHS, 11 store, 00 no-op.
- req_base_addr  in  ADDR_W  byte base address.
- req_len  in  LEN_W  word count.
- req_stride  in  ADDR_W  byte stride (used only with optional feature).
- rd_valid/rd_ready  out/in  1  load data stream handshake.
- rd_data  out  DATA_W  load data.
- wr_valid/wr_ready  in/out  1  store data stream handshake.
- wr_data  in  DATA_W  store data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky ICB error flag for the current/last burst.
- nice_icb_cmd_valid/ready  out/in  1  ICB command handshake.
- nice_icb_cmd_addr  out  ADDR_W.
- nice_icb_cmd_read  out  1.
- nice_icb_cmd_wdata  out  DATA_W.
- nice_icb_cmd_size  out  2  constant 2'b10.
- nice_icb_rsp_valid/ready  in/out  1.
- nice_icb_rsp_rdata  in  DATA_W.
- nice_icb_rsp_err  in  1.
- nice_mem_holdup  out  1  equals busy.

Behaviour:
- Reset:
  - All outputs 0, except nice_icb_cmd_size = 2'b10 and req_ready = 1.
  - FIFO emptied, counters cleared, state = IDLE.
  - Reset mid-burst abandons the burst with no done pulse; in-flight responses arriving after reset are ignored.
- Request acceptance (IDLE):
  - On req_valid & req_ready, latch op/base/len/stride, clear err, set idx = 0 and outst = 0.
  - If op = 00 or len = 0, go to DONE; otherwise go to ISSUE.
- ISSUE, load:
  - nice_icb_cmd_valid = (outst + fifo_cnt < MAX_OUTST).
  - addr = base + idx*4.
  - cmd_read = 1.
- ISSUE, store:
  - nice_icb_cmd_valid = wr_valid & (outst < MAX_OUTST).
  - wr_ready = nice_icb_cmd_ready & that condition; combinational, no data skid.
  - cmd_wdata = wr_data.
  - cmd_read = 0.
- Command fire (cmd_valid & cmd_ready):
  - idx++ and outst++.
  - Once idx reaches len, go to DRAIN.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Cmd valid/addr/read/wdata are held stable while valid & !ready.
- Responses:
  - nice_icb_rsp_ready = 1 while busy; never back-pressures, because FIFO space is reserved at issue.
  - Response fire: outst--.
  - A load response is pushed into the FIFO, including when rsp_err = 1, so word count is preserved.
  - rsp_err = 1 sets err (sticky).
  - Simultaneous cmd fire and rsp fire leave outst unchanged.
- FIFO:
  - rd_valid = !empty; rd_data = head; pop on rd_valid & rd_ready.
  - Minimum latency: 1 cycle from rsp fire to rd_valid.
  - Same-cycle push and pop when full or empty is supported.
- DRAIN: wait until outst = 0 and the FIFO is empty, then go to DONE.
- DONE: done = 1 for one cycle, then IDLE. busy = 0 in DONE.
- busy and nice_mem_holdup are high in ISSUE and DRAIN.
- err holds its value until the next request is accepted.
- Responses are assumed in order (ICB guarantee); a response with outst = 0 is ignored.

Optional Feature:
- Macro: NICE_MEMIF_STRIDE_EN.
- Defined: addr = base + idx*stride, with stride taken from req_stride latched at accept. Stride 0 repeats the same address; addition wraps modulo 2^ADDR_W.
- Undefined: req_stride is ignored and stride is fixed at 4 bytes.

Test Plan:
- Load LHS, base 0x1000, len 4, cmd_ready = 1, 1-cycle rsp, rdata 0xA0..0xA3, rd_ready = 1:
  - cmd addrs 0x1000/0x1004/0x1008/0x100C with read = 1.
  - rd_data A0..A3 in order.
  - done pulses once; err = 0.
- Load len 8, rd_ready = 0, MAX_OUTST = 4:
  - exactly 4 cmds issued, then cmd_valid = 0.
  - raising rd_ready resumes issue; 8 words delivered in order.
- Store, base 0x2000, len 3, wdata 11/22/33, cmd_ready toggling 1-0-1:
  - wr_ready high only on fire cycles.
  - cmd addrs 0x2000..0x2008 with read = 0; wdata matches.
  - done pulses after the 3rd rsp.
- Load len 4, rsp_err = 1 on 2nd rsp:
  - 4 words still delivered.
  - err = 1 at done and held until the next accept.
- len = 0 or op = 00:
  - no cmd_valid; done pulses on the cycle after accept; busy stays 0.
- nice_rst asserted with 2 outstanding:
  - next cycle all outputs are at reset values and req_ready = 1.
  - a following len-2 load completes normally.
- With NICE_MEMIF_STRIDE_EN, base 0xFFFFFFF8, stride 8, len 3 → addrs 0xFFFFFFF8, 0x00000000, 0x00000008.
